// File: rtl/core_mem_pkg.sv
// Shared types for the data-memory responder: FSM states, operation kind and counter width.
package core_mem_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, RESP, WAIT_DROP} mem_resp_state_t;
    typedef enum logic {OP_RD, OP_WR} mem_op_t;

    // Wide enough for LATENCY-1 with LATENCY up to 15.
    localparam int unsigned CNT_BITS = 4;

endpackage

// File: rtl/mem_array_1r1w.sv
// Storage array with a registered read port and a core write port that overrides
// a same-address host preload write on the same edge.
module mem_array_1r1w #(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [DATA_BITS-1:0] rd_data,
    input  logic                 core_we,
    input  logic [ADDR_BITS-1:0] core_addr,
    input  logic [DATA_BITS-1:0] core_wdata,
    input  logic                 host_we,
    input  logic [ADDR_BITS-1:0] host_addr,
    input  logic [DATA_BITS-1:0] host_wdata
);

    localparam int unsigned Depth = 2 ** ADDR_BITS;

    logic [DATA_BITS-1:0] mem [Depth];
    logic [DATA_BITS-1:0] rd_data_q;

    // Contents survive reset. The core write is issued last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (host_we) begin
            mem[host_addr] <= host_wdata;
        end
        if (core_we) begin
            mem[core_addr] <= core_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core's data-memory read/write channels: accepts one request,
// waits LATENCY cycles, then pulses the matching ready for one cycle.
module data_mem_responder
    import core_mem_pkg::*;
#(
    parameter int unsigned DATA_MEM_ADDR_BITS = 8,
    parameter int unsigned DATA_MEM_DATA_BITS = 8,
    parameter int unsigned LATENCY            = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          data_mem_read_valid,
    input  logic [DATA_MEM_ADDR_BITS-1:0] data_mem_read_address,
    output logic                          data_mem_read_ready,
    output logic [DATA_MEM_DATA_BITS-1:0] data_mem_read_data,
    input  logic                          data_mem_write_valid,
    input  logic [DATA_MEM_ADDR_BITS-1:0] data_mem_write_address,
    input  logic [DATA_MEM_DATA_BITS-1:0] data_mem_write_data,
    output logic                          data_mem_write_ready,
    input  logic                          host_we,
    input  logic [DATA_MEM_ADDR_BITS-1:0] host_addr,
    input  logic [DATA_MEM_DATA_BITS-1:0] host_wdata,
    output logic                          busy
);

    mem_resp_state_t               state_q, state_d;
    mem_op_t                       op_q, op_d;
    logic [CNT_BITS-1:0]           cnt_q, cnt_d;
    logic [DATA_MEM_ADDR_BITS-1:0] addr_q, addr_d;
    logic [DATA_MEM_DATA_BITS-1:0] wdata_q, wdata_d;
    logic                          read_ready_q, read_ready_d;
    logic                          write_ready_q, write_ready_d;
    logic                          busy_q;
    logic                          rd_en, core_we;
    logic                          served_valid;

    assign served_valid = (op_q == OP_WR) ? data_mem_write_valid : data_mem_read_valid;

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        read_ready_d  = 1'b0;
        write_ready_d = 1'b0;
        rd_en         = 1'b0;
        core_we       = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Write wins a simultaneous request; the read stays pending for a later pass.
                if (data_mem_write_valid) begin
                    op_d    = OP_WR;
                    addr_d  = data_mem_write_address;
                    wdata_d = data_mem_write_data;
                    cnt_d   = CNT_BITS'(LATENCY - 1);
                    state_d = BUSY;
                end else if (data_mem_read_valid) begin
                    op_d    = OP_RD;
                    addr_d  = data_mem_read_address;
                    cnt_d   = CNT_BITS'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = RESP;
                    if (op_q == OP_WR) begin
                        core_we       = 1'b1;
                        write_ready_d = 1'b1;
                    end else begin
                        rd_en        = 1'b1;
                        read_ready_d = 1'b1;
                    end
                end
            end
            RESP: begin
                state_d = served_valid ? WAIT_DROP : IDLE;
            end
            WAIT_DROP: begin
                // Hold off until the served request is withdrawn so it is not answered twice.
                if (!served_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            op_q          <= OP_RD;
            cnt_q         <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            read_ready_q  <= 1'b0;
            write_ready_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            read_ready_q  <= read_ready_d;
            write_ready_q <= write_ready_d;
            busy_q        <= (state_d != IDLE);
        end
    end

    mem_array_1r1w #(
        .ADDR_BITS(DATA_MEM_ADDR_BITS),
        .DATA_BITS(DATA_MEM_DATA_BITS)
    ) u_mem (
        .clk       (clk),
        .reset     (reset),
        .rd_en     (rd_en),
        .rd_addr   (addr_q),
        .rd_data   (data_mem_read_data),
        .core_we   (core_we),
        .core_addr (addr_q),
        .core_wdata(wdata_q),
        .host_we   (host_we),
        .host_addr (host_addr),
        .host_wdata(host_wdata)
    );

    assign data_mem_read_ready  = read_ready_q;
    assign data_mem_write_ready = write_ready_q;
    assign busy                 = busy_q;

endmodule
